// File: rtl/tpu_pkg.sv
// Shared definitions for the Mini TPU instruction path: opcodes, fixed
// instruction words, field positions and the sequencer state encoding.
package tpu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int INSTR_W    = 16;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // STORE r0c0 with no data: harmless to the control unit when idle
    localparam logic [INSTR_W-1:0] IDLE_WORD = 16'hC000;
    localparam logic [INSTR_W-1:0] STOP_WORD = 16'h4000;

    // Instruction fields: {opcode, sel, rsv, row, col, imm}
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 14;
    localparam int SEL_BIT = 13;
    localparam int RSV_BIT = 12;
    localparam int ROW_MSB = 11;
    localparam int ROW_LSB = 10;
    localparam int COL_MSB = 9;
    localparam int COL_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FINISH  = 2'd2
    } seq_state_e;

    function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/tpu_instr_fifo.sv
// Synchronous FIFO for host instructions. Power-of-two depth so pointers
// wrap naturally. A push is refused while full even if a pop happens in
// the same cycle; the head is only visible the cycle after it is written.
module tpu_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rptr_q];
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wr_data_i;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tpu_instr_sequencer.sv
// Issues buffered host instructions to the Mini TPU control unit, one per
// cycle, holding LOAD/STORE/START back while a START-opened compute window
// is running and closing that window with an automatic STOP.
// Optional macro TPU_SEQ_PERF_EN adds busy/stall cycle counters.
module tpu_instr_sequencer
    import tpu_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int COMPUTE_CYCLES = 11,
    parameter int CNT_W          = 4,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   in_instr,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [15:0]   out_instr,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [CW-1:0] fifo_count
`ifdef TPU_SEQ_PERF_EN
    ,
    output logic [15:0]   perf_compute_cycles,
    output logic [15:0]   perf_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      instr_q, instr_d;
    logic             vld_q, vld_d, done_q, done_d, abort_q, abort_d;
    logic             pop, full, empty;
    logic [15:0]      head;
    logic [1:0]       head_op;

    tpu_instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (in_valid),
        .wr_data_i (in_instr),
        .pop_i     (pop),
        .rd_data_o (head),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (fifo_count)
    );

    assign head_op   = instr_op(head);
    assign in_ready  = !full;
    assign busy      = (state_q == ST_COMPUTE);
    assign out_instr = instr_q;
    assign out_valid = vld_q;
    assign done      = done_q;
    assign aborted   = abort_q;

    // Next state, pop decision and the word to present next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        instr_d = IDLE_WORD;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    instr_d = head;
                    vld_d   = 1'b1;
                    if (head_op == OP_START) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_COMPUTE: begin
                // A host STOP takes priority over expiry in the same cycle
                if (!empty && head_op == OP_STOP) begin
                    pop     = 1'b1;
                    instr_d = head;
                    vld_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    instr_d = STOP_WORD;
                    vld_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, counter and issue register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            instr_q <= IDLE_WORD;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

`ifdef TPU_SEQ_PERF_EN
    logic [15:0] perf_c_q, perf_s_q;
    logic        stall;

    assign stall               = busy && !empty && (head_op != OP_STOP);
    assign perf_compute_cycles = perf_c_q;
    assign perf_stall_cycles   = perf_s_q;

    // Saturating busy and stall cycle counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_c_q <= '0;
            perf_s_q <= '0;
        end else begin
            if (busy && perf_c_q != 16'hFFFF)  perf_c_q <= perf_c_q + 1'b1;
            if (stall && perf_s_q != 16'hFFFF) perf_s_q <= perf_s_q + 1'b1;
        end
    end
`endif

endmodule
